// File: rtl/iomem_timer.sv
// Memory-mapped prescaled 32-bit timer with compare/reload, sticky match flag and level irq.
// Optional PWM output/DUTY register enabled by defining IOMEM_TIMER_PWM_EN.
module iomem_timer #(
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter logic [31:0] CTRL_RESET     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    input  logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_rdata,
    output logic        irq,
    output logic        pwm_out
);

    logic                      ready_q, ready_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      irq_q, irq_d;
    logic [2:0]                ctrl_q, ctrl_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [31:0]               count_q, count_d;
    logic [31:0]               compare_q, compare_d;
    logic                      match_q, match_d;

    logic        acc;
    logic        wr;
    logic        tick;
    logic        match_set;
    logic        match_clr;
    logic [31:0] cur;
    logic [31:0] wr_val;

    // Dummy reduction keeps the undecoded address bits from tripping lint.
    logic unused_addr;
    assign unused_addr = ^{iomem_addr[31:5], iomem_addr[1:0]};

`ifdef IOMEM_TIMER_PWM_EN
    logic [31:0] duty_q, duty_d;
    logic        pwm_q, pwm_d;
`endif

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [3:0]  st);
        logic [31:0] res;
        res = old;
        for (int unsigned b = 0; b < 4; b++) begin
            if (st[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

    always_comb begin
        case (iomem_addr[4:2])
            3'd0:    cur = {29'b0, ctrl_q};
            3'd1:    cur = 32'(prescale_q);
            3'd2:    cur = count_q;
            3'd3:    cur = compare_q;
            3'd4:    cur = {31'b0, match_q};
`ifdef IOMEM_TIMER_PWM_EN
            3'd5:    cur = duty_q;
`endif
            default: cur = '0;
        endcase
    end

    assign acc    = iomem_valid && !ready_q;
    assign wr     = acc && (iomem_wstrb != 4'b0000);
    assign wr_val = merge_bytes(cur, iomem_wdata, iomem_wstrb);

    always_comb begin
        ready_d    = acc;
        rdata_d    = acc ? cur : rdata_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        count_d    = count_q;
        compare_d  = compare_q;
        tick       = 1'b0;
        match_set  = 1'b0;
        match_clr  = 1'b0;

        // Timer evolution first; bus writes below override it where they collide.
        if (ctrl_q[0]) begin
            if (pcnt_q == prescale_q) begin
                tick   = 1'b1;
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
            end
        end

        if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                if (ctrl_q[1]) count_d = '0;
                else           ctrl_d[0] = 1'b0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr) begin
            case (iomem_addr[4:2])
                3'd0: ctrl_d = wr_val[2:0];
                3'd1: begin
                    prescale_d = wr_val[PRESCALE_WIDTH-1:0];
                    pcnt_d     = '0;
                end
                3'd2: begin
                    count_d = wr_val;
                    pcnt_d  = '0;
                end
                3'd3: compare_d = wr_val;
                3'd4: match_clr = iomem_wstrb[0] && iomem_wdata[0];
                default: ;
            endcase
        end

        // A new match in the same cycle as a W1C leaves MATCH set.
        match_d = (match_q && !match_clr) || match_set;
        irq_d   = match_q && ctrl_q[2];
    end

`ifdef IOMEM_TIMER_PWM_EN
    always_comb begin
        duty_d = duty_q;
        if (wr && iomem_addr[4:2] == 3'd5) duty_d = wr_val;
        pwm_d = ctrl_q[0] && (count_q < duty_q);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            ctrl_q     <= CTRL_RESET[2:0];
            prescale_q <= '0;
            pcnt_q     <= '0;
            count_q    <= '0;
            compare_q  <= '1;
            match_q    <= 1'b0;
`ifdef IOMEM_TIMER_PWM_EN
            duty_q     <= '0;
            pwm_q      <= 1'b0;
`endif
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
`ifdef IOMEM_TIMER_PWM_EN
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
`endif
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = irq_q;
`ifdef IOMEM_TIMER_PWM_EN
    assign pwm_out     = pwm_q;
`else
    assign pwm_out     = 1'b0;
`endif

endmodule

// File: doc/iomem_timer.md
Name: iomem_timer

Overview:
- Memory-mapped timer peripheral on the SoC iomem bus, in the 0x0300_0000+ window, directly downstream of the SoC address decoder.
- Provides a prescaled 32-bit up-counter, a compare/reload register, a sticky match flag and a level interrupt.
- Answers the core's valid/ready request with one registered wait state.

Parameters:
- PRESCALE_WIDTH, 16, width of the prescaler register and prescaler counter.
- CTRL_RESET, 32'h0, reset value of CTRL.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- iomem_valid  in  1  request for this block; held by the master until ready
- iomem_ready  out  1  one-cycle acknowledge
- iomem_addr  in  32  byte address; only [4:2] decoded
- iomem_wdata  in  32  write data
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_rdata  out  32  read data, valid while iomem_ready=1
- irq  out  1  match interrupt, level
- pwm_out  out  1  PWM output (see Optional Feature)

Behaviour:
- Reset (async, rst=1): iomem_ready=0, iomem_rdata=0, irq=0, pwm_out=0, CTRL=CTRL_RESET, PRESCALE=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, prescaler counter=0.
- Register map, addr[4:2]:
  - 0 CTRL: [0] EN, [1] AUTORELOAD, [2] IRQEN; other bits read 0.
  - 1 PRESCALE: [PRESCALE_WIDTH-1:0]; other bits read 0.
  - 2 COUNT.
  - 3 COMPARE.
  - 4 STATUS: [0] MATCH, write-1-to-clear.
  - 5 DUTY: PWM only.
  - 6, 7 unmapped: reads return 0, writes are ignored, and they still acknowledge.
- Handshake:
  - Cycle N: iomem_valid=1 and iomem_ready=0 → the write is performed (byte lanes per wstrb) and the read data is sampled.
  - Cycle N+1: iomem_ready=1 with iomem_rdata valid.
  - Cycle N+2: iomem_ready=0 regardless of iomem_valid.
  - Result: at most one access every 2 cycles; no duplicate write for one request.
  - iomem_rdata holds its last value while ready=0.
- Tick: when EN=1, the prescaler counter increments each cycle. On reaching PRESCALE it returns to 0 and asserts a one-cycle tick, so the divide ratio is PRESCALE+1. PRESCALE=0 gives a tick every cycle.
- EN=0: prescaler counter and COUNT hold their values.
- On tick:
  - If COUNT==COMPARE: set MATCH. If AUTORELOAD, COUNT←0; otherwise COUNT holds and EN←0 (one-shot).
  - Else: COUNT←COUNT+1, wrapping 32'hFFFF_FFFF→0 without setting MATCH.
- Simultaneous events:
  - Bus write to COUNT in a tick cycle: the written value wins and the prescaler counter resets to 0.
  - Bus write to PRESCALE: the prescaler counter resets to 0.
  - Bus write of EN=1 in the same cycle as a one-shot auto-clear: the bus write wins.
  - W1C of MATCH in the same cycle a new match sets it: MATCH stays 1.
  - A read of COUNT returns the value before that cycle's update.
- irq = MATCH & IRQEN, registered (1 cycle after MATCH/IRQEN change).
- Reset asserted mid-access: iomem_ready drops immediately and the pending access is discarded. The master must reissue it.

Optional Feature:
- Macro: IOMEM_TIMER_PWM_EN.
- Defined:
  - DUTY register is implemented (reset 0).
  - pwm_out is registered as (EN && COUNT < DUTY).
  - DUTY=0 gives constant 0; DUTY>COMPARE with AUTORELOAD gives constant 1 while EN=1.
- Undefined:
  - DUTY reads 0 and writes are ignored.
  - pwm_out is tied to 0.

Test Plan:
- Read after reset: read 0x0300_0000, 0x08, 0x0C → 0, 0, 32'hFFFF_FFFF. iomem_ready is high exactly 1 cycle, 1 cycle after valid.
- Prescaled count: PRESCALE=3, COMPARE=100, CTRL=3 (EN+AUTORELOAD) → COUNT increments every 4 cycles. After COUNT=100 the next tick gives COUNT=0, MATCH=1.
- One-shot with irq:
  - Setup: PRESCALE=0, COMPARE=5, CTRL=5 (EN+IRQEN), COUNT=0 → after 6 ticks MATCH=1, EN reads 0, COUNT stays 5, irq=1 one cycle later.
  - Write STATUS=1 → irq=0.
- Wrap: COUNT=32'hFFFF_FFFE, COMPARE=3, PRESCALE=0, EN=1 → COUNT goes FFFF_FFFF, 0, 1, 2, 3, then MATCH. MATCH is not set at the wrap.
- Collisions:
  - W1C on STATUS in the same cycle a match occurs → MATCH reads 1.
  - Byte write wstrb=4'b0010 of 32'hAB00 to COMPARE=32'hFFFF_FFFF → COMPARE=32'hFFFF_ABFF.
- PWM (macro defined): COMPARE=9, DUTY=3, AUTORELOAD, PRESCALE=0 → pwm_out high for 3 of every 10 cycles. With the macro undefined, pwm_out=0 and DUTY reads 0.
